// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
//   DEPTH-entry instruction queue sitting on the IF/ID pipeline boundary.
//   Fetch pushes {pc_plus_4, instruction} with a valid/ready handshake. Decode
//   sees the head entry, split into fixed MIPS fields. While the queue is empty
//   every decode field reads as zero, which forms a NOP bubble. A taken
//   branch or jump raises flush, and flush discards every held entry.
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous, active-high reset
//   if_valid          fetch presents an entry
//   if_ready          queue can accept (not full; depends on state only)
//   if_pc_plus_4      fetched PC+4
//   if_instruction    fetched instruction
//   flush             synchronous discard of all entries
//   id_stall          decode holds the head entry
//   id_valid          head entry valid
//   id_pc_plus_4      head PC+4
//   id_rs/rt/rd       instr[25:21] / [20:16] / [15:11]
//   id_beq_offset     instr[15:0]
//   id_opcode         instr[31:26]
//   id_function_code  instr[5:0]
//   occupancy         number of entries held (0..DEPTH)
// -----------------------------------------------------------------------------
module if_id_queue #(
  parameter  int unsigned PC_W    = 32,
  parameter  int unsigned INSTR_W = 32,
  parameter  int unsigned DEPTH   = 4,
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [PC_W-1:0]    if_pc_plus_4,
  input  logic [INSTR_W-1:0] if_instruction,
  input  logic               flush,
  input  logic               id_stall,
  output logic               id_valid,
  output logic [PC_W-1:0]    id_pc_plus_4,
  output logic [4:0]         id_rs,
  output logic [4:0]         id_rt,
  output logic [4:0]         id_rd,
  output logic [15:0]        id_beq_offset,
  output logic [5:0]         id_opcode,
  output logic [5:0]         id_function_code,
  output logic [CNT_W-1:0]   occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = PC_W + INSTR_W;

  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               full;
  logic               push;
  logic               pop;
  logic [ENT_W-1:0]   head;
  logic [INSTR_W-1:0] head_instr;
  logic [PC_W-1:0]    head_pc;

  // if_ready comes from the counter alone. This keeps id_stall and flush off the
  // fetch handshake path. A pop into a full queue therefore frees the slot
  // one cycle later.
  always_comb begin
    full     = (cnt_q == CNT_W'(DEPTH));
    if_ready = !full;
    id_valid = (cnt_q != '0);
    push     = if_valid && !full && !flush;
    pop      = id_valid && !id_stall && !flush;

    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage has no reset. Stale contents never reach decode because the
  // outputs are masked with id_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {if_pc_plus_4, if_instruction};
  end

  always_comb begin
    head       = mem_q[rptr_q];
    head_instr = head[INSTR_W-1:0];
    head_pc    = head[ENT_W-1:INSTR_W];

    id_pc_plus_4     = id_valid ? head_pc           : '0;
    id_opcode        = id_valid ? head_instr[31:26] : '0;
    id_rs            = id_valid ? head_instr[25:21] : '0;
    id_rt            = id_valid ? head_instr[20:16] : '0;
    id_rd            = id_valid ? head_instr[15:11] : '0;
    id_beq_offset    = id_valid ? head_instr[15:0]  : '0;
    id_function_code = id_valid ? head_instr[5:0]   : '0;
    occupancy        = cnt_q;
  end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  localparam logic [31:0] I0 = 32'h8C22_0004; // lw  $2, 4($1)
  localparam logic [31:0] I1 = 32'h0043_0820; // add $1, $2, $3
  localparam logic [31:0] I2 = 32'h1062_FFFE; // beq $3, $2, -2
  localparam logic [31:0] I3 = 32'hAC85_0008; // sw  $5, 8($4)
  localparam logic [31:0] I4 = 32'h0800_0010; // j   0x10

  logic               clk = 1'b0;
  logic               reset;
  logic               if_valid;
  logic               if_ready;
  logic [PC_W-1:0]    if_pc_plus_4;
  logic [INSTR_W-1:0] if_instruction;
  logic               flush;
  logic               id_stall;
  logic               id_valid;
  logic [PC_W-1:0]    id_pc_plus_4;
  logic [4:0]         id_rs;
  logic [4:0]         id_rt;
  logic [4:0]         id_rd;
  logic [15:0]        id_beq_offset;
  logic [5:0]         id_opcode;
  logic [5:0]         id_function_code;
  logic [CNT_W-1:0]   occupancy;

  int n_cmp = 0;
  int n_err = 0;

  if_id_queue #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_pc_plus_4     (if_pc_plus_4),
    .if_instruction   (if_instruction),
    .flush            (flush),
    .id_stall         (id_stall),
    .id_valid         (id_valid),
    .id_pc_plus_4     (id_pc_plus_4),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_rd            (id_rd),
    .id_beq_offset    (id_beq_offset),
    .id_opcode        (id_opcode),
    .id_function_code (id_function_code),
    .occupancy        (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Fetch must hold its data while stalled by a full queue.
  logic            prev_block = 1'b0;
  logic [PC_W-1:0] prev_pc    = '0;
  logic [31:0]     prev_ins   = '0;
  always @(posedge clk) begin
    if (!reset && prev_block && if_valid)
      assert (if_pc_plus_4 == prev_pc && if_instruction == prev_ins)
        else $error("FAIL protocol: fetch data changed while blocked");
    prev_block <= if_valid && !if_ready;
    prev_pc    <= if_pc_plus_4;
    prev_ins   <= if_instruction;
  end

  always @(negedge clk) begin
    if (!reset)
      assert (occupancy <= CNT_W'(DEPTH))
        else $error("FAIL occupancy_bound: occupancy %0d exceeds depth", occupancy);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every decode output is checked against fields sliced from the expected
  // instruction. A bubble passes all-zero expectations.
  task automatic chk_head(input string tag, input logic ev, input logic [31:0] epc,
                          input logic [31:0] eins);
    chk({tag, " id_valid"},  64'(id_valid),         64'(ev));
    chk({tag, " pc_plus_4"}, 64'(id_pc_plus_4),     64'(epc));
    chk({tag, " opcode"},    64'(id_opcode),        64'(eins[31:26]));
    chk({tag, " rs"},        64'(id_rs),            64'(eins[25:21]));
    chk({tag, " rt"},        64'(id_rt),            64'(eins[20:16]));
    chk({tag, " rd"},        64'(id_rd),            64'(eins[15:11]));
    chk({tag, " offset"},    64'(id_beq_offset),    64'(eins[15:0]));
    chk({tag, " funct"},     64'(id_function_code), 64'(eins[5:0]));
  endtask

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        fl;
    logic        st;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eins;
    logic [2:0]  eocc;
    logic        erdy;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  vec_t vt [20];
  ent_t sb [$];

  initial begin
    //          v     pc            ins   fl    st    ev    epc           eins  eocc  erdy
    vt[0]  = '{1'b1, 32'h0000_0004, I0,   1'b0, 1'b1, 1'b1, 32'h0000_0004, I0,   3'd1, 1'b1};
    vt[1]  = '{1'b1, 32'h0000_0008, I1,   1'b0, 1'b1, 1'b1, 32'h0000_0004, I0,   3'd2, 1'b1};
    vt[2]  = '{1'b1, 32'h0000_000C, I2,   1'b0, 1'b1, 1'b1, 32'h0000_0004, I0,   3'd3, 1'b1};
    vt[3]  = '{1'b1, 32'h0000_0010, I3,   1'b0, 1'b1, 1'b1, 32'h0000_0004, I0,   3'd4, 1'b0};
    vt[4]  = '{1'b1, 32'h0000_0014, I4,   1'b0, 1'b1, 1'b1, 32'h0000_0004, I0,   3'd4, 1'b0};
    vt[5]  = '{1'b1, 32'h0000_0014, I4,   1'b0, 1'b0, 1'b1, 32'h0000_0008, I1,   3'd3, 1'b1};
    vt[6]  = '{1'b1, 32'h0000_0014, I4,   1'b0, 1'b1, 1'b1, 32'h0000_0008, I1,   3'd4, 1'b0};
    vt[7]  = '{1'b0, 32'h0,         32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_000C, I2,   3'd3, 1'b1};
    vt[8]  = '{1'b0, 32'h0,         32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, I3,   3'd2, 1'b1};
    vt[9]  = '{1'b0, 32'h0,         32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0014, I4,   3'd1, 1'b1};
    vt[10] = '{1'b0, 32'h0,         32'h0, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0, 3'd0, 1'b1};
    vt[11] = '{1'b0, 32'h0,         32'h0, 1'b0, 1'b1, 1'b0, 32'h0,          32'h0, 3'd0, 1'b1};
    vt[12] = '{1'b0, 32'h0,         32'h0, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0, 3'd0, 1'b1};
    vt[13] = '{1'b0, 32'h0,         32'h0, 1'b0, 1'b1, 1'b0, 32'h0,          32'h0, 3'd0, 1'b1};
    vt[14] = '{1'b1, 32'h0000_0100, I1,   1'b0, 1'b1, 1'b1, 32'h0000_0100, I1,   3'd1, 1'b1};
    vt[15] = '{1'b1, 32'h0000_0104, I2,   1'b0, 1'b1, 1'b1, 32'h0000_0100, I1,   3'd2, 1'b1};
    vt[16] = '{1'b1, 32'h0000_0108, I3,   1'b0, 1'b1, 1'b1, 32'h0000_0100, I1,   3'd3, 1'b1};
    vt[17] = '{1'b1, 32'h0000_010C, I4,   1'b1, 1'b0, 1'b0, 32'h0,          32'h0, 3'd0, 1'b1};
    vt[18] = '{1'b1, 32'h0000_0200, I0,   1'b0, 1'b1, 1'b1, 32'h0000_0200, I0,   3'd1, 1'b1};
    vt[19] = '{1'b1, 32'h0000_0204, I2,   1'b0, 1'b0, 1'b1, 32'h0000_0204, I2,   3'd1, 1'b1};

    reset          = 1'b1;
    if_valid       = 1'b0;
    if_pc_plus_4   = '0;
    if_instruction = '0;
    flush          = 1'b0;
    id_stall       = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset occupancy", 64'(occupancy), 64'd0);
    chk("reset if_ready",  64'(if_ready),  64'd1);
    chk_head("reset", 1'b0, 32'h0, 32'h0);

    foreach (vt[i]) begin
      if_valid       = vt[i].v;
      if_pc_plus_4   = vt[i].pc;
      if_instruction = vt[i].ins;
      flush          = vt[i].fl;
      id_stall       = vt[i].st;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d occupancy", i), 64'(occupancy), 64'(vt[i].eocc));
      chk($sformatf("vec%0d if_ready", i),  64'(if_ready),  64'(vt[i].erdy));
      chk_head($sformatf("vec%0d", i), vt[i].ev, vt[i].epc, vt[i].eins);
    end
    flush = 1'b0;

    // Hand-decoded check of the first load instruction.
    chk("lw opcode literal", 64'(I0[31:26]), 64'h23);

    // Continuous streaming: the queue holds one entry and the pointers wrap
    // several times.
    sb.delete();
    sb.push_back('{32'h0000_0204, I2});
    for (int i = 0; i < 20; i++) begin
      ent_t e;
      e.pc  = 32'h0000_1000 + 32'(4 * i);
      e.ins = $urandom;
      if_valid       = 1'b1;
      if_pc_plus_4   = e.pc;
      if_instruction = e.ins;
      id_stall       = 1'b0;
      sb.push_back(e);
      void'(sb.pop_front());
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d occupancy", i), 64'(occupancy), 64'(sb.size()));
      chk($sformatf("stream%0d pc", i),  64'(id_pc_plus_4), 64'(sb[0].pc));
      chk($sformatf("stream%0d ins", i), 64'({id_opcode, id_rs, id_rt, id_beq_offset}),
          64'(sb[0].ins));
    end

    // Asynchronous reset in the middle of a burst, between clock edges.
    if_pc_plus_4   = 32'h0000_2000;
    if_instruction = I3;
    id_stall       = 1'b1;
    @(posedge clk);
    #1;
    chk("pre-reset occupancy", 64'(occupancy), 64'd2);
    if_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async reset occupancy", 64'(occupancy), 64'd0);
    chk("async reset if_ready",  64'(if_ready),  64'd1);
    chk_head("async reset", 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #3 reset = 1'b0;
    if_valid       = 1'b1;
    if_pc_plus_4   = 32'h0000_0300;
    if_instruction = I3;
    id_stall       = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset occupancy", 64'(occupancy), 64'd1);
    chk_head("post-reset", 1'b1, 32'h0000_0300, I3);
    if_valid = 1'b0;
    id_stall = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset drain occupancy", 64'(occupancy), 64'd0);
    chk_head("post-reset drain", 1'b0, 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
